// File: rtl/selector_rr_arbiter_pkg.sv
// Shared constants for the 4-lane selector arbiter: FSM states, lane count, select codes.
// Optional hold-time preemption is built in when SELECTOR_ARB_HOLD_LIMIT_EN is defined.
package selector_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int NUM_LANES    = 4;
  localparam int MAX_HOLD_DEF = 8;

  // {s1,s0} codes presented to the shared 4:1 selector
  localparam logic [1:0] SEL_L0 = 2'b00;
  localparam logic [1:0] SEL_L1 = 2'b01;
  localparam logic [1:0] SEL_L2 = 2'b10;
  localparam logic [1:0] SEL_L3 = 2'b11;

  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [1:0] idx);
    lane_onehot = {{(NUM_LANES-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/selector_rr_arbiter_rr_pick4.sv
// Rotate-priority encoder: first requesting lane searching last+1, last+2, last+3, last.
// Purely combinational; idx is meaningful only when any is high.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       any,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Walk the search order backwards so the earliest hit is the last assignment.
  always_comb begin
    any  = |req;
    idx  = last;
    cand = last;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/selector_rr_arbiter.sv
// Round-robin owner of a shared 4:1 selector; registered gnt/s1:s0 drive the datapath directly.
// Optional preemption after MAX_HOLD cycles when SELECTOR_ARB_HOLD_LIMIT_EN is defined.
module selector_rr_arbiter
  import selector_arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic [1:0] owner
);

`ifdef SELECTOR_ARB_HOLD_LIMIT_EN
  localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(MAX_HOLD);
`else
  // Debug-only counter saturating at all-ones; MAX_HOLD has no effect on the result.
  localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(MAX_HOLD | ((1 << HOLD_W) - 1));
`endif

  arb_state_t            state_q, state_d;
  logic [NUM_LANES-1:0]  gnt_q,   gnt_d;
  logic [1:0]            sel_q,   sel_d;
  logic [1:0]            last_q,  last_d;
  logic [HOLD_W-1:0]     hold_q,  hold_d;
  logic                  busy_q,  busy_d;

  logic                  pick_any;
  logic [1:0]            pick_idx;
  logic                  others_req;

  rr_pick4 u_pick (
    .req  (req),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign others_req = |(req & ~lane_onehot(last_q));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    hold_d  = hold_q;

    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (pick_any) begin
          state_d = ST_GRANT;
          gnt_d   = lane_onehot(pick_idx);
          sel_d   = pick_idx;
          last_d  = pick_idx;
          hold_d  = HOLD_W'(1);
        end
      end

      ST_GRANT: begin
        if (req[last_q]) begin
`ifdef SELECTOR_ARB_HOLD_LIMIT_EN
          if (hold_q == HOLD_TOP) begin
            hold_d = HOLD_W'(1);
            if (others_req) begin
              gnt_d  = lane_onehot(pick_idx);
              sel_d  = pick_idx;
              last_d = pick_idx;
            end
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
`else
          if (hold_q != HOLD_TOP) begin
            hold_d = hold_q + HOLD_W'(1);
          end
`endif
        end else if (pick_any) begin
          // Owner released: hand straight over, no idle bubble on the selector.
          gnt_d  = lane_onehot(pick_idx);
          sel_d  = pick_idx;
          last_d = pick_idx;
          hold_d = HOLD_W'(1);
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = |gnt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= SEL_L0;
      last_q  <= SEL_L3;
      hold_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt   = gnt_q;
  assign s0    = sel_q[0];
  assign s1    = sel_q[1];
  assign busy  = busy_q;
  assign owner = last_q;

endmodule

// File: tb/tb_selector_rr_arbiter.sv
// Scoreboard bench for selector_rr_arbiter: directed rotation/handoff/hold/reset cases plus random req.
// Expectations follow SELECTOR_ARB_HOLD_LIMIT_EN when it is defined for the build.
module tb_selector_rr_arbiter;

  localparam int MAXH = 4;
`ifdef SELECTOR_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_LIMIT = 1'b1;
`else
  localparam bit HOLD_LIMIT = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req   = 4'b0000;
  logic [3:0] gnt;
  logic       s0, s1, busy;
  logic [1:0] owner;

  always #5 clk = ~clk;

  selector_rr_arbiter #(.MAX_HOLD(MAXH), .HOLD_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .s0    (s0),
    .s1    (s1),
    .busy  (busy),
    .owner (owner)
  );

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic [1:0] owner;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic       m_busy;
  logic [1:0] m_own;
  logic [1:0] m_sel;
  int         m_hold;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic compare_head();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 8'd0, 8'd1);
      return;
    end
    e = exp_q.pop_front();
    check({e.tag, "/gnt"},   8'(gnt),      8'(e.gnt));
    check({e.tag, "/sel"},   8'({s1, s0}), 8'(e.sel));
    check({e.tag, "/busy"},  8'(busy),     8'(e.busy));
    check({e.tag, "/owner"}, 8'(owner),    8'(e.owner));
  endtask

  // Drive req just after an edge, queue what the next edge must produce, then compare.
  task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [1:0] sel,
                      input logic b, input logic [1:0] own, input string tag);
    exp_t e;
    req     = r;
    e.tag   = tag;
    e.gnt   = g;
    e.sel   = sel;
    e.busy  = b;
    e.owner = own;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/gnt"},   8'(gnt),      8'h0);
    check({tag, "/sel"},   8'({s1, s0}), 8'h0);
    check({tag, "/busy"},  8'(busy),     8'h0);
    check({tag, "/owner"}, 8'(owner),    8'h3);
  endtask

  function automatic logic [1:0] rr_next(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] c;
    for (int k = 1; k <= 4; k++) begin
      c = 2'((int'(last) + k) % 4);
      if (r[c]) return c;
    end
    return last;
  endfunction

  task automatic model_step(input logic [3:0] r);
    logic [3:0] others;
    others = r & ~(4'b0001 << m_own);
    if (!m_busy) begin
      if (r != 4'b0000) begin
        m_busy = 1'b1;
        m_own  = rr_next(r, m_own);
        m_sel  = m_own;
        m_hold = 1;
      end
    end else if (!r[m_own]) begin
      if (r != 4'b0000) begin
        m_own  = rr_next(r, m_own);
        m_sel  = m_own;
        m_hold = 1;
      end else begin
        m_busy = 1'b0;
      end
    end else if (HOLD_LIMIT && m_hold == MAXH) begin
      if (others != 4'b0000) begin
        m_own = rr_next(r, m_own);
        m_sel = m_own;
      end
      m_hold = 1;
    end else if (m_hold < 15) begin
      m_hold++;
    end
  endtask

  initial begin
    logic [3:0] r;
    logic [1:0] idx;

    // Reset values
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // 1: single requester, grant then release; select holds last owner
    step(4'b0001, 4'b0001, 2'd0, 1'b1, 2'd0, "t1_grant");
    step(4'b0001, 4'b0001, 2'd0, 1'b1, 2'd0, "t1_hold");
    step(4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0, "t1_release");

    // 2: all lanes requesting, owners drop briefly -> 0,1,2,3,0 with no gaps
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t2_reset");
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(4'b1111, 4'b0001, 2'd0, 1'b1, 2'd0, "t2_l0");
    step(4'b1111, 4'b0001, 2'd0, 1'b1, 2'd0, "t2_l0b");
    step(4'b1110, 4'b0010, 2'd1, 1'b1, 2'd1, "t2_l1");
    step(4'b1111, 4'b0010, 2'd1, 1'b1, 2'd1, "t2_l1b");
    step(4'b1101, 4'b0100, 2'd2, 1'b1, 2'd2, "t2_l2");
    step(4'b1111, 4'b0100, 2'd2, 1'b1, 2'd2, "t2_l2b");
    step(4'b1011, 4'b1000, 2'd3, 1'b1, 2'd3, "t2_l3");
    step(4'b1111, 4'b1000, 2'd3, 1'b1, 2'd3, "t2_l3b");
    step(4'b0111, 4'b0001, 2'd0, 1'b1, 2'd0, "t2_wrap");

    // 3: after lane 2, lanes 0 and 3 pending -> lane 3 wins
    step(4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0, "t3_idle");
    step(4'b0100, 4'b0100, 2'd2, 1'b1, 2'd2, "t3_l2");
    step(4'b0100, 4'b0100, 2'd2, 1'b1, 2'd2, "t3_l2b");
    step(4'b1001, 4'b1000, 2'd3, 1'b1, 2'd3, "t3_rr");
    step(4'b0000, 4'b0000, 2'd3, 1'b0, 2'd3, "t3_idle2");

    // 4: lane 1 holds while lane 0 waits; preempted after MAXH cycles only with the limit
    step(4'b0010, 4'b0010, 2'd1, 1'b1, 2'd1, "t4_l1");
    for (int k = 0; k < 8; k++) begin
      if (HOLD_LIMIT && k >= 3 && k < 7)
        step(4'b0011, 4'b0001, 2'd0, 1'b1, 2'd0, $sformatf("t4_k%0d", k));
      else
        step(4'b0011, 4'b0010, 2'd1, 1'b1, 2'd1, $sformatf("t4_k%0d", k));
    end

    // 5: asynchronous reset between edges while granted
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t5_async");
    req = 4'b1111;
    #2 rst_n = 1'b1;
    step(4'b1111, 4'b0001, 2'd0, 1'b1, 2'd0, "t5_first");

    // 6: random req against the model, with structural invariants every cycle
    m_busy = 1'b1;
    m_own  = 2'd0;
    m_sel  = 2'd0;
    m_hold = 1;
    r      = 4'b1111;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      model_step(r);
      step(r, m_busy ? (4'b0001 << m_own) : 4'b0000, m_sel, m_busy, m_own, "rand");
      check("inv_onehot", 8'($onehot0(gnt)), 8'h1);
      check("inv_busy", 8'(busy), 8'(|gnt));
      if (busy) begin
        idx = 2'd0;
        for (int b = 0; b < 4; b++) if (gnt[b]) idx = 2'(b);
        check("inv_sel", 8'({s1, s0}), 8'(idx));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
